// File: rtl/aui_pkg.sv
// Shared constants and types for the AUI alignment-marker insertion path.
package aui_pkg;

  localparam int AM_BLOCKS   = 4;
  localparam int AM_MAPPED_W = 1028;
  localparam int AM_LANES    = 16;

  localparam logic [67:0] AM_PAD0 = 68'h6666_6666_6666_6666_6;
  localparam logic [64:0] AM_PAD1 = 65'h6666_6666_6666_6666;

  typedef logic [256:0] block_t;

  // Lane j marker: every nibble equals j.
  localparam logic [119:0] AM_TABLE [0:AM_LANES-1] = '{
    {30{4'h0}}, {30{4'h1}}, {30{4'h2}}, {30{4'h3}},
    {30{4'h4}}, {30{4'h5}}, {30{4'h6}}, {30{4'h7}},
    {30{4'h8}}, {30{4'h9}}, {30{4'ha}}, {30{4'hb}},
    {30{4'hc}}, {30{4'hd}}, {30{4'he}}, {30{4'hf}}
  };

endpackage

// File: rtl/aui_am_mapper.sv
// Combinational mapping of the 16-lane AM table into two 1028-bit AM groups.
module aui_am_mapper
  import aui_pkg::*;
(
  input  logic [2:0]             i_status,
  output logic [AM_MAPPED_W-1:0] o_map_0,
  output logic [AM_MAPPED_W-1:0] o_map_1
);

  // Interleave 20-bit lane slices per group; flow 0 takes the low half, flow 1 the high half.
  always_comb begin
    o_map_0 = '0;
    o_map_1 = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned j = 0; j < AM_LANES; j++) begin
        o_map_0[320*k + 20*j +: 20] = AM_TABLE[j][40*k      +: 20];
        o_map_1[320*k + 20*j +: 20] = AM_TABLE[j][40*k + 20 +: 20];
      end
    end
    o_map_0[1027:960]  = AM_PAD0;
    o_map_1[1024:960]  = AM_PAD1;
    o_map_1[1027:1025] = i_status;
  end

endmodule

// File: rtl/aui_am_inserter.sv
// AM insertion stage: each period opens with a 4-block AM group, then payload.
module aui_am_inserter
  import aui_pkg::*;
#(
  parameter  int BITS_BLOCK    = 257,
  parameter  int PERIOD_BLOCKS = 40,
  localparam int CNT_W         = $clog2(PERIOD_BLOCKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BITS_BLOCK-1:0] i_flow_0,
  input  logic [BITS_BLOCK-1:0] i_flow_1,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_am_en,
  input  logic [2:0]            i_status,
  output logic [BITS_BLOCK-1:0] o_flow_0,
  output logic [BITS_BLOCK-1:0] o_flow_1,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_am,
  output logic                  o_sop,
  output logic [CNT_W-1:0]      o_block_idx
);

  logic [CNT_W-1:0]       r_cnt;
  logic                   r_am_en_q;
  logic [2:0]             r_status_q;

  logic                   w_cnt_zero;
  logic                   w_cnt_last;
  logic                   w_am_eff;
  logic [2:0]             w_status_eff;
  logic                   w_am_phase;
  logic                   w_load;
  logic                   w_take;
  logic                   w_adv;
  logic [AM_MAPPED_W-1:0] w_map_0;
  logic [AM_MAPPED_W-1:0] w_map_1;
  logic [BITS_BLOCK-1:0]  w_am_blk_0;
  logic [BITS_BLOCK-1:0]  w_am_blk_1;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_last = (r_cnt == CNT_W'(PERIOD_BLOCKS - 1));

  // At a period start the live enable/status apply before they are latched.
  assign w_am_eff     = w_cnt_zero ? i_am_en  : r_am_en_q;
  assign w_status_eff = w_cnt_zero ? i_status : r_status_q;
  assign w_am_phase   = w_am_eff && (r_cnt < CNT_W'(AM_BLOCKS));

  assign w_load  = !o_valid || i_ready;
  assign w_take  = w_load && !w_am_phase && i_valid;
  assign w_adv   = (w_load && w_am_phase) || w_take;
  assign o_ready = w_load && !w_am_phase;

  aui_am_mapper u_mapper (
    .i_status (w_status_eff),
    .o_map_0  (w_map_0),
    .o_map_1  (w_map_1)
  );

  assign w_am_blk_0 = w_map_0[BITS_BLOCK*int'(r_cnt[1:0]) +: BITS_BLOCK];
  assign w_am_blk_1 = w_map_1[BITS_BLOCK*int'(r_cnt[1:0]) +: BITS_BLOCK];

  // Period counter and per-period AM enable/status capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_am_en_q  <= 1'b1;
      r_status_q <= '0;
    end else if (w_adv) begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      if (w_cnt_zero) begin
        r_am_en_q  <= i_am_en;
        r_status_q <= i_status;
      end
    end
  end

  // Output register: loads AM or payload, or drops valid on an upstream gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_flow_0    <= '0;
      o_flow_1    <= '0;
      o_valid     <= 1'b0;
      o_am        <= 1'b0;
      o_sop       <= 1'b0;
      o_block_idx <= '0;
    end else if (w_load) begin
      if (w_am_phase) begin
        o_flow_0    <= w_am_blk_0;
        o_flow_1    <= w_am_blk_1;
        o_valid     <= 1'b1;
        o_am        <= 1'b1;
        o_sop       <= w_cnt_zero;
        o_block_idx <= r_cnt;
      end else if (i_valid) begin
        o_flow_0    <= i_flow_0;
        o_flow_1    <= i_flow_1;
        o_valid     <= 1'b1;
        o_am        <= 1'b0;
        o_sop       <= w_cnt_zero;
        o_block_idx <= r_cnt;
      end else begin
        o_valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aui_am_inserter.sv
// Directed-vector bench for aui_am_inserter.
module tb_aui_am_inserter;
  import aui_pkg::*;

  localparam int BB = 257;
  localparam int PB = 40;
  localparam int CW = $clog2(PB);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BB-1:0] i_flow_0, i_flow_1;
  logic          i_valid, o_ready, i_am_en, i_ready;
  logic [2:0]    i_status;
  logic [BB-1:0] o_flow_0, o_flow_1;
  logic          o_valid, o_am, o_sop;
  logic [CW-1:0] o_block_idx;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1027:0] exp_m0, exp_m1;

  always #5 clk = ~clk;

  aui_am_inserter #(.BITS_BLOCK(BB), .PERIOD_BLOCKS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .i_flow_0(i_flow_0), .i_flow_1(i_flow_1),
    .i_valid(i_valid), .o_ready(o_ready), .i_am_en(i_am_en), .i_status(i_status),
    .o_flow_0(o_flow_0), .o_flow_1(o_flow_1), .o_valid(o_valid), .i_ready(i_ready),
    .o_am(o_am), .o_sop(o_sop), .o_block_idx(o_block_idx)
  );

  // Reference AM group: bit i (<960) belongs to lane ((i mod 320)/20), nibble value = lane.
  function automatic logic [1027:0] ref_map(input bit f, input logic [2:0] st);
    logic [1027:0] v;
    int lane;
    v = '0;
    for (int i = 0; i < 960; i++) begin
      lane = (i % 320) / 20;
      v[i] = lane[i % 4];
    end
    if (!f) v[1027:960] = 68'h6666_6666_6666_6666_6;
    else begin
      v[1024:960]  = 65'h6666_6666_6666_6666;
      v[1027:1025] = st;
    end
    return v;
  endfunction

  function automatic logic [BB-1:0] pay(input int n, input bit f);
    logic [BB-1:0] v;
    v = BB'(n);
    return f ? ~v : v;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int n, input bit v);
    i_flow_0 = pay(n, 1'b0);
    i_flow_1 = pay(n, 1'b1);
    i_valid  = v;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_ready = 1'b1; i_am_en = 1'b1; i_status = 3'b101;
    drive(0, 1'b0);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({o_valid, o_am, o_sop, o_block_idx} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0", {o_valid, o_am, o_sop, o_block_idx});
    end
    n_tests++;
    if ({o_flow_0, o_flow_1} !== '0) begin
      n_fail++; $display("FAIL reset_flow: got %h / %h want 0", o_flow_0, o_flow_1);
    end
    n_tests++;
    if (o_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", o_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_am_group;
    exp_m0 = ref_map(1'b0, 3'b101);
    exp_m1 = ref_map(1'b1, 3'b101);
    for (int b = 0; b < 4; b++) begin
      tick();
      n_tests++;
      if ({o_valid, o_am, o_sop, o_block_idx} !== {1'b1, 1'b1, (b == 0), CW'(b)}) begin
        n_fail++; $display("FAIL am_ctrl blk %0d: got v%b am%b sop%b idx%0d", b, o_valid, o_am, o_sop, o_block_idx);
      end
      n_tests++;
      if (o_flow_0 !== exp_m0[BB*b +: BB] || o_flow_1 !== exp_m1[BB*b +: BB]) begin
        n_fail++; $display("FAIL am_data blk %0d: got %h want %h", b, o_flow_0, exp_m0[BB*b +: BB]);
      end
      if (b < 3) begin
        n_tests++;
        if (o_ready !== 1'b0) begin
          n_fail++; $display("FAIL am_ready blk %0d: got %b want 0", b, o_ready);
        end
      end
      if (b == 0) begin
        n_tests++;
        if (o_flow_0[39:20] !== 20'h11111) begin
          n_fail++; $display("FAIL am_lane1: got %h want 11111", o_flow_0[39:20]);
        end
      end
      if (b == 3) begin
        n_tests++;
        if (o_flow_1[256:254] !== 3'b101) begin
          n_fail++; $display("FAIL am_status: got %b want 101", o_flow_1[256:254]);
        end
        n_tests++;
        if (o_flow_0[256:189] !== 68'h6666_6666_6666_6666_6) begin
          n_fail++; $display("FAIL am_pad0: got %h want 66666666666666666", o_flow_0[256:189]);
        end
      end
    end
  endtask

  task automatic test_payload_wrap;
    for (int n = 0; n < 36; n++) begin
      drive(n, 1'b1);
      tick();
      n_tests++;
      if ({o_valid, o_am, o_sop, o_block_idx} !== {1'b1, 1'b0, 1'b0, CW'(n + 4)}) begin
        n_fail++; $display("FAIL pay_ctrl %0d: got v%b am%b sop%b idx%0d want idx %0d", n, o_valid, o_am, o_sop, o_block_idx, n + 4);
      end
      n_tests++;
      if (o_flow_0 !== pay(n, 1'b0) || o_flow_1 !== pay(n, 1'b1)) begin
        n_fail++; $display("FAIL pay_data %0d: got %h want %h", n, o_flow_0, pay(n, 1'b0));
      end
      n_tests++;
      if (o_ready !== (n < 35)) begin
        n_fail++; $display("FAIL pay_ready %0d: got %b want %b", n, o_ready, (n < 35));
      end
    end
    drive(0, 1'b0);
    tick();
    n_tests++;
    if ({o_valid, o_am, o_sop, o_block_idx} !== {1'b1, 1'b1, 1'b1, CW'(0)}) begin
      n_fail++; $display("FAIL wrap_am0: got v%b am%b sop%b idx%0d", o_valid, o_am, o_sop, o_block_idx);
    end
  endtask

  task automatic test_backpressure;
    for (int b = 1; b < 3; b++) begin
      tick();
      n_tests++;
      if ({o_am, o_block_idx} !== {1'b1, CW'(b)}) begin
        n_fail++; $display("FAIL bp_am blk %0d: got am%b idx%0d", b, o_am, o_block_idx);
      end
    end
    i_ready = 1'b0; i_status = 3'b011;
    drive(999, 1'b1);
    repeat (5) begin
      #1;
      n_tests++;
      if (o_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_am_ready: got %b want 0", o_ready);
      end
      tick();
      n_tests++;
      if ({o_valid, o_am, o_sop, o_block_idx} !== {1'b1, 1'b1, 1'b0, CW'(2)} || o_flow_0 !== exp_m0[BB*2 +: BB]) begin
        n_fail++; $display("FAIL bp_am_hold: got am%b idx%0d data %h", o_am, o_block_idx, o_flow_0);
      end
    end
    i_ready = 1'b1;
    drive(0, 1'b0);
    tick();
    n_tests++;
    if ({o_am, o_block_idx} !== {1'b1, CW'(3)} || o_flow_1[256:254] !== 3'b101) begin
      n_fail++; $display("FAIL bp_am3: got am%b idx%0d status %b want status 101", o_am, o_block_idx, o_flow_1[256:254]);
    end
    for (int m = 0; m < 36; m++) begin
      drive(200 + m, 1'b1);
      tick();
      n_tests++;
      if ({o_valid, o_am, o_block_idx} !== {1'b1, 1'b0, CW'(m + 4)} || o_flow_0 !== pay(200 + m, 1'b0)) begin
        n_fail++; $display("FAIL bp_pay %0d: got idx%0d data %h want %h", m, o_block_idx, o_flow_0, pay(200 + m, 1'b0));
      end
      if (m == 7) begin
        i_ready = 1'b0;
        drive(208, 1'b1);
        repeat (5) begin
          #1;
          n_tests++;
          if (o_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_pay_ready: got %b want 0", o_ready);
          end
          tick();
          n_tests++;
          if ({o_valid, o_block_idx} !== {1'b1, CW'(11)} || o_flow_0 !== pay(207, 1'b0)) begin
            n_fail++; $display("FAIL bp_pay_hold: got idx%0d data %h want %h", o_block_idx, o_flow_0, pay(207, 1'b0));
          end
        end
        i_ready = 1'b1;
      end
    end
    drive(0, 1'b0);
    tick();
    n_tests++;
    if ({o_am, o_sop, o_block_idx} !== {1'b1, 1'b1, CW'(0)}) begin
      n_fail++; $display("FAIL bp_wrap: got am%b sop%b idx%0d", o_am, o_sop, o_block_idx);
    end
  endtask

  task automatic test_gaps;
    for (int b = 1; b < 4; b++) begin
      tick();
      n_tests++;
      if ({o_am, o_block_idx} !== {1'b1, CW'(b)}) begin
        n_fail++; $display("FAIL gap_am blk %0d: got am%b idx%0d", b, o_am, o_block_idx);
      end
    end
    n_tests++;
    if (o_flow_1[256:254] !== 3'b011) begin
      n_fail++; $display("FAIL gap_status: got %b want 011", o_flow_1[256:254]);
    end
    for (int m = 0; m < 36; m++) begin
      drive(300 + m, 1'b1);
      tick();
      n_tests++;
      if ({o_valid, o_am, o_block_idx} !== {1'b1, 1'b0, CW'(m + 4)} || o_flow_0 !== pay(300 + m, 1'b0)) begin
        n_fail++; $display("FAIL gap_pay %0d: got v%b idx%0d data %h", m, o_valid, o_block_idx, o_flow_0);
      end
      if (m % 3 == 1) begin
        drive(0, 1'b0);
        tick();
        n_tests++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
          n_fail++; $display("FAIL gap_bubble %0d: got v%b rdy%b want v0 rdy1", m, o_valid, o_ready);
        end
      end
    end
    drive(0, 1'b0);
    tick();
    n_tests++;
    if ({o_valid, o_am, o_sop, o_block_idx} !== {1'b1, 1'b1, 1'b1, CW'(0)}) begin
      n_fail++; $display("FAIL gap_wrap: got v%b am%b sop%b idx%0d", o_valid, o_am, o_sop, o_block_idx);
    end
  endtask

  task automatic test_bypass;
    repeat (3) tick();
    for (int m = 0; m < 36; m++) begin
      drive(500 + m, 1'b1);
      tick();
    end
    n_tests++;
    if ({o_am, o_block_idx} !== {1'b0, CW'(39)}) begin
      n_fail++; $display("FAIL byp_pre: got am%b idx%0d want idx 39", o_am, o_block_idx);
    end
    i_am_en = 1'b0;
    for (int m = 0; m < 40; m++) begin
      drive(600 + m, 1'b1);
      if (m == 5) i_am_en = 1'b1;
      tick();
      n_tests++;
      if ({o_valid, o_am, o_sop, o_block_idx} !== {1'b1, 1'b0, (m == 0), CW'(m)} || o_flow_1 !== pay(600 + m, 1'b1)) begin
        n_fail++; $display("FAIL byp_pay %0d: got am%b sop%b idx%0d data %h", m, o_am, o_sop, o_block_idx, o_flow_1);
      end
      if (m == 0) begin
        n_tests++;
        if (o_ready !== 1'b1) begin
          n_fail++; $display("FAIL byp_ready: got %b want 1", o_ready);
        end
      end
    end
    n_tests++;
    if (o_ready !== 1'b0) begin
      n_fail++; $display("FAIL byp_end_ready: got %b want 0", o_ready);
    end
    drive(0, 1'b0);
    tick();
    n_tests++;
    if ({o_am, o_sop, o_block_idx} !== {1'b1, 1'b1, CW'(0)}) begin
      n_fail++; $display("FAIL byp_am_return: got am%b sop%b idx%0d", o_am, o_sop, o_block_idx);
    end
  endtask

  task automatic test_midreset;
    repeat (3) tick();
    i_status = 3'b010;
    for (int m = 0; m < 9; m++) begin
      drive(700 + m, 1'b1);
      tick();
    end
    n_tests++;
    if ({o_am, o_block_idx} !== {1'b0, CW'(12)}) begin
      n_fail++; $display("FAIL rst_pre: got am%b idx%0d want idx 12", o_am, o_block_idx);
    end
    #2 rst_n = 1'b0;
    drive(0, 1'b0);
    #1;
    n_tests++;
    if ({o_valid, o_am, o_sop, o_block_idx, o_ready} !== '0 || {o_flow_0, o_flow_1} !== '0) begin
      n_fail++; $display("FAIL rst_mid: got v%b am%b sop%b idx%0d rdy%b", o_valid, o_am, o_sop, o_block_idx, o_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_m0 = ref_map(1'b0, 3'b010);
    exp_m1 = ref_map(1'b1, 3'b010);
    for (int b = 0; b < 4; b++) begin
      tick();
      n_tests++;
      if ({o_valid, o_am, o_sop, o_block_idx} !== {1'b1, 1'b1, (b == 0), CW'(b)} ||
          o_flow_0 !== exp_m0[BB*b +: BB] || o_flow_1 !== exp_m1[BB*b +: BB]) begin
        n_fail++; $display("FAIL rst_am blk %0d: got am%b sop%b idx%0d f1 %h want %h", b, o_am, o_sop, o_block_idx, o_flow_1, exp_m1[BB*b +: BB]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_am_group();
    test_payload_wrap();
    test_backpressure();
    test_gaps();
    test_bypass();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
